// File: rtl/sag4fun_pkg.sv
// Shared types and constants for the sheep-and-goats engine arbiter.
package sag4fun_pkg;

    // Controller states. ISSUE states hold the engine start request until the
    // engine accepts it; WAIT states count out the fixed engine latency.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LDM_ISSUE = 3'd1,
        OP_ISSUE  = 3'd2,
        LDM_WAIT  = 3'd3,
        OP_WAIT   = 3'd4,
        RESP      = 3'd5
    } state_t;

    // Engine op latency for the two supported datapath widths.
    localparam int LAT32 = 5;
    localparam int LAT64 = 6;

endpackage

// File: rtl/sag4fun_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr,
// wrapping around, reported both one-hot and as an index.
module sag4fun_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [IDW-1:0] cand [NREQ];

    // Requester index examined at each search offset from the pointer.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IDW:0] sum;
            assign sum = {1'b0, ptr} + (IDW+1)'(gi);
            assign cand[gi] = (sum >= (IDW+1)'(NREQ)) ?
                              IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];
        end
    endgenerate

    // Scan offsets from farthest to nearest so the nearest valid one wins.
    always_comb begin
        idx   = '0;
        any   = 1'b0;
        grant = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (valid[cand[k]]) begin
                idx = cand[k];
                any = 1'b1;
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sag4fun_arbiter.sv
// Shares one sequential sheep-and-goats engine between NREQ requesters with
// round-robin arbitration, a one-entry mask cache and a tagged response port.
module sag4fun_arbiter
    import sag4fun_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int LAT  = LAT32,
    parameter int IDW  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_inv,
    input  logic [NREQ*N-1:0] req_data,
    input  logic [NREQ*N-1:0] req_mask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_data,
    output logic              eng_ctrl_inv,
    output logic              eng_ctrl_msk,
    output logic              eng_ctrl_ldm,
    output logic              eng_ctrl_start,
    input  logic              eng_ctrl_ready,
    output logic [N-1:0]      eng_in_data,
    input  logic [N-1:0]      eng_out_data
);

    localparam int CW = $clog2(LAT + 1);

    // Latched request record for the single outstanding op.
    typedef struct packed {
        logic [IDW-1:0] id;
        logic           inv;
        logic [N-1:0]   data;
        logic [N-1:0]   mask;
    } req_t;

    logic [N-1:0] data_arr [NREQ];
    logic [N-1:0] mask_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*N +: N];
            assign mask_arr[gi] = req_mask[gi*N +: N];
        end
    endgenerate

    state_t          state_reg, state_next;
    req_t            req_reg, req_next;
    logic [IDW-1:0]  ptr_reg, ptr_next;
    logic            cache_valid_reg, cache_valid_next;
    logic [N-1:0]    cache_mask_reg, cache_mask_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            rsp_valid_reg, rsp_valid_next;
    logic [IDW-1:0]  rsp_id_reg, rsp_id_next;
    logic [N-1:0]    rsp_data_reg, rsp_data_next;
    logic            eng_inv_reg, eng_ldm_reg;
    logic [N-1:0]    eng_data_reg;

    logic [NREQ-1:0] pick_grant;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;

    sag4fun_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // State and datapath registers; engine controls remember their last value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            req_reg         <= '0;
            ptr_reg         <= '0;
            cache_valid_reg <= 1'b0;
            cache_mask_reg  <= '0;
            cnt_reg         <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_id_reg      <= '0;
            rsp_data_reg    <= '0;
            eng_inv_reg     <= 1'b0;
            eng_ldm_reg     <= 1'b0;
            eng_data_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            req_reg         <= req_next;
            ptr_reg         <= ptr_next;
            cache_valid_reg <= cache_valid_next;
            cache_mask_reg  <= cache_mask_next;
            cnt_reg         <= cnt_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_id_reg      <= rsp_id_next;
            rsp_data_reg    <= rsp_data_next;
            eng_inv_reg     <= eng_ctrl_inv;
            eng_ldm_reg     <= eng_ctrl_ldm;
            eng_data_reg    <= eng_in_data;
        end
    end

    // Next-state, accept and engine-control decode.
    always_comb begin
        state_next       = state_reg;
        req_next         = req_reg;
        ptr_next         = ptr_reg;
        cache_valid_next = cache_valid_reg;
        cache_mask_next  = cache_mask_reg;
        cnt_next         = cnt_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_id_next      = rsp_id_reg;
        rsp_data_next    = rsp_data_reg;
        req_ready        = '0;
        eng_ctrl_start   = 1'b0;
        eng_ctrl_ldm     = eng_ldm_reg;
        eng_ctrl_inv     = eng_inv_reg;
        eng_in_data      = eng_data_reg;

        // A flush drops the cache; a completing mask load below overrides it.
        if (flush) begin
            cache_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    req_ready     = pick_grant;
                    req_next.id   = pick_idx;
                    req_next.inv  = req_inv[pick_idx];
                    req_next.data = data_arr[pick_idx];
                    req_next.mask = mask_arr[pick_idx];
                    ptr_next = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
                    if (cache_valid_reg && !flush &&
                        (mask_arr[pick_idx] == cache_mask_reg)) begin
                        state_next = OP_ISSUE;
                    end else begin
                        state_next = LDM_ISSUE;
                    end
                end
            end
            LDM_ISSUE: begin
                eng_ctrl_start = 1'b1;
                eng_ctrl_ldm   = 1'b1;
                eng_ctrl_inv   = 1'b0;
                eng_in_data    = req_reg.mask;
                if (eng_ctrl_ready) begin
                    cnt_next   = CW'(LAT - 1);
                    state_next = LDM_WAIT;
                end
            end
            LDM_WAIT: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (eng_ctrl_ready) begin
                    cache_mask_next  = req_reg.mask;
                    cache_valid_next = 1'b1;
                    state_next       = OP_ISSUE;
                end
            end
            OP_ISSUE: begin
                eng_ctrl_start = 1'b1;
                eng_ctrl_ldm   = 1'b0;
                eng_ctrl_inv   = req_reg.inv;
                eng_in_data    = req_reg.data;
                if (eng_ctrl_ready) begin
                    cnt_next   = CW'(LAT - 1);
                    state_next = OP_WAIT;
                end
            end
            OP_WAIT: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (eng_ctrl_ready) begin
                    rsp_data_next  = eng_out_data;
                    rsp_id_next    = req_reg.id;
                    rsp_valid_next = 1'b1;
                    state_next     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign eng_ctrl_msk = 1'b0;
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_id       = rsp_id_reg;
    assign rsp_data     = rsp_data_reg;

endmodule

// File: tb/tb_sag4fun_arbiter.sv
// Directed bench for sag4fun_arbiter with a behavioural engine stand-in.
module tb_sag4fun_arbiter;

    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int LAT  = 5;
    localparam int IDW  = 2;

    localparam logic [31:0] DIN = 32'hB3389E39;
    localparam logic [31:0] MSK = 32'h690AEA75;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_inv = '0;
    logic [NREQ*N-1:0] req_data = '0;
    logic [NREQ*N-1:0] req_mask = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_data;
    logic              eng_ctrl_inv, eng_ctrl_msk, eng_ctrl_ldm, eng_ctrl_start;
    logic              eng_ctrl_ready;
    logic [N-1:0]      eng_in_data, eng_out_data;

    int errors = 0;
    int checks = 0;

    sag4fun_arbiter #(.N(N), .NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_inv        (req_inv),
        .req_data       (req_data),
        .req_mask       (req_mask),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_data       (rsp_data),
        .eng_ctrl_inv   (eng_ctrl_inv),
        .eng_ctrl_msk   (eng_ctrl_msk),
        .eng_ctrl_ldm   (eng_ctrl_ldm),
        .eng_ctrl_start (eng_ctrl_start),
        .eng_ctrl_ready (eng_ctrl_ready),
        .eng_in_data    (eng_in_data),
        .eng_out_data   (eng_out_data)
    );

    always #5 clock = ~clock;

    // Engine stand-in: the reference vector returns the known SAG/ISG results,
    // anything else a simple mask-dependent scramble.
    function automatic logic [31:0] eng_fn(input logic [31:0] d, input logic [31:0] m, input bit inv);
        if (d == DIN && m == MSK) return inv ? 32'h43CF83E3 : 32'h4CCB5A6D;
        return d ^ {m[15:0], m[31:16]} ^ (inv ? 32'hFFFF0000 : 32'h0);
    endfunction

    logic [31:0] m_mask, m_out;
    int          m_cnt;
    logic        eng_hold = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_cnt  <= 0;
            m_mask <= '0;
            m_out  <= '0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end else if (eng_ctrl_start && eng_ctrl_ready) begin
            m_cnt <= LAT - 1;
            if (eng_ctrl_ldm) m_mask <= eng_in_data;
            else              m_out  <= eng_fn(eng_in_data, m_mask, eng_ctrl_inv);
        end
    end
    assign eng_ctrl_ready = (m_cnt == 0) && !eng_hold;
    assign eng_out_data   = m_out;

    // Count accepted engine starts and remember the last load mask.
    int          ldm_cnt = 0, op_cnt = 0;
    logic [31:0] last_ldm = '0;
    always @(posedge clock) begin
        if (!reset && eng_ctrl_start && eng_ctrl_ready) begin
            if (eng_ctrl_ldm) begin
                ldm_cnt  <= ldm_cnt + 1;
                last_ldm <= eng_in_data;
            end else begin
                op_cnt <= op_cnt + 1;
            end
        end
    end

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int id, input bit inv, input logic [31:0] d, input logic [31:0] m);
        req_data[id*N +: N] = d;
        req_mask[id*N +: N] = m;
        req_inv[id]         = inv;
    endtask

    // Wait up to a bound for rsp_valid; returns the number of edges waited.
    task automatic wait_rsp(input int hold, output int e);
        e = 0;
        eng_hold = (hold > 0);
        while (!rsp_valid && e < 200) begin
            tick();
            e++;
            eng_hold = (e < hold);
        end
        eng_hold = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk(rsp_valid == 1'b0, "rsp_valid_drop", 64'(rsp_valid), 0);
    endtask

    // One complete transaction from a single requester.
    task automatic do_req(input int id, input bit inv, input logic [31:0] d, input logic [31:0] m,
                          input bit acc_flush, input bit miss, input int hold);
        int l0, o0, w, e, exp_lat;
        logic [31:0] exp_d;
        logic [NREQ-1:0] exp_g;
        l0 = ldm_cnt;
        o0 = op_cnt;
        exp_g = '0;
        exp_g[id] = 1'b1;
        exp_d = eng_fn(d, m, inv);
        set_req(id, inv, d, m);
        req_valid = exp_g;
        flush = acc_flush;
        #1;
        w = 0;
        while (req_ready != exp_g && w < 20) begin
            tick();
            w++;
        end
        chk(req_ready == exp_g, "req_ready_grant", 64'(req_ready), 64'(exp_g));
        tick();
        req_valid = '0;
        flush = 1'b0;
        wait_rsp(hold, e);
        // Visible from cycle t+2+LAT (hit) or t+3+2*LAT (miss) after accept edge t.
        exp_lat = (miss ? 2 * LAT + 2 : LAT + 1) + hold;
        chk(e == exp_lat, "latency", 64'(e), 64'(exp_lat));
        chk(rsp_id == IDW'(id), "rsp_id", 64'(rsp_id), 64'(id));
        chk(rsp_data == exp_d, "rsp_data", 64'(rsp_data), 64'(exp_d));
        chk((ldm_cnt - l0) == (miss ? 1 : 0), "ldm_starts", 64'(ldm_cnt - l0), 64'(miss));
        chk((op_cnt - o0) == 1, "op_starts", 64'(op_cnt - o0), 1);
        if (miss) chk(last_ldm == m, "ldm_data", 64'(last_ldm), 64'(m));
        $display("txn id=%0d inv=%0d data=%08h mask=%08h miss=%0d lat=%0d rsp=%08h", id, inv, d, m, miss, e, rsp_data);
        handshake();
    endtask

    typedef struct {
        int          id;
        bit          inv;
        logic [31:0] data;
        logic [31:0] mask;
        bit          pre_flush;
        bit          acc_flush;
        bit          miss;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int e, w, o0, ok_stable, ok_noready;
        logic [31:0] exp3, exp1, hold_d;

        vecs[0] = '{0, 1'b0, DIN,          MSK,          1'b0, 1'b0, 1'b1};
        vecs[1] = '{2, 1'b1, DIN,          MSK,          1'b0, 1'b0, 1'b0};
        vecs[2] = '{1, 1'b0, 32'h12345678, MSK,          1'b0, 1'b0, 1'b0};
        vecs[3] = '{3, 1'b1, 32'hCAFEF00D, 32'h0000FFFF, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{0, 1'b0, 32'h00000000, 32'h0000FFFF, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{2, 1'b0, DIN,          32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1, 1'b1, DIN,          32'hFFFFFFFF, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{3, 1'b0, DIN,          32'hFFFFFFFF, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{0, 1'b0, 32'hA5A5A5A5, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};

        repeat (3) tick();
        chk(rsp_valid == 1'b0 && rsp_id == '0 && rsp_data == '0, "reset_rsp", 64'(rsp_data), 0);
        chk(eng_ctrl_start == 1'b0 && eng_in_data == '0 && eng_ctrl_msk == 1'b0, "reset_eng", 64'(eng_in_data), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].pre_flush) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end
            do_req(vecs[i].id, vecs[i].inv, vecs[i].data, vecs[i].mask,
                   vecs[i].acc_flush, vecs[i].miss, 0);
        end

        // Round robin from pointer 3 with requesters 1 and 3 pending.
        do_req(2, 1'b0, 32'h0BADBEEF, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
        set_req(3, 1'b0, 32'hCAFEF00D, 32'hFFFFFFFF);
        set_req(1, 1'b1, 32'h0F0F0F0F, 32'hFFFFFFFF);
        exp3 = eng_fn(32'hCAFEF00D, 32'hFFFFFFFF, 1'b0);
        exp1 = eng_fn(32'h0F0F0F0F, 32'hFFFFFFFF, 1'b1);
        req_valid = 4'b1010;
        #1;
        chk(req_ready == 4'b1000, "rr_first", 64'(req_ready), 64'h8);
        tick();
        req_valid = 4'b0010;
        ok_noready = 1;
        e = 0;
        while (!rsp_valid && e < 200) begin
            if (req_ready != '0) ok_noready = 0;
            tick();
            e++;
        end
        chk(rsp_valid && rsp_id == 2'd3, "rr_rsp_id3", 64'(rsp_id), 3);
        chk(rsp_data == exp3, "rr_rsp_data3", 64'(rsp_data), 64'(exp3));
        // Backpressure: response held for 10 cycles, no accepts meanwhile.
        ok_stable = 1;
        hold_d = rsp_data;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!rsp_valid || rsp_data != hold_d || rsp_id != 2'd3) ok_stable = 0;
            if (req_ready != '0) ok_noready = 0;
        end
        chk(ok_stable == 1, "bp_stable", 64'(ok_stable), 1);
        rsp_ready = 1'b1;
        #1;
        chk(req_ready == '0, "bp_no_accept_on_hs", 64'(req_ready), 0);
        chk(ok_noready == 1, "bp_req_ready_zero", 64'(ok_noready), 1);
        tick();
        rsp_ready = 1'b0;
        chk(req_ready == 4'b0010, "rr_second", 64'(req_ready), 64'h2);
        $display("txn rr id=3 rsp=%08h", hold_d);
        tick();
        req_valid = '0;
        wait_rsp(0, e);
        chk(rsp_valid && rsp_id == 2'd1, "rr_rsp_id1", 64'(rsp_id), 1);
        chk(rsp_data == exp1, "rr_rsp_data1", 64'(rsp_data), 64'(exp1));
        $display("txn rr id=1 rsp=%08h", rsp_data);
        handshake();

        // Reset in the middle of OP_WAIT.
        o0 = op_cnt;
        set_req(0, 1'b0, DIN, 32'h13579BDF);
        req_valid = 4'b0001;
        w = 0;
        while (op_cnt == o0 && w < 50) begin
            tick();
            w++;
            if (req_ready == '0) req_valid = '0;
        end
        req_valid = '0;
        chk(op_cnt != o0, "rst_op_started", 64'(op_cnt - o0), 1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk(rsp_valid == 1'b0 && rsp_id == '0 && rsp_data == '0, "rst_async_rsp", 64'(rsp_valid), 0);
        chk(req_ready == '0 && eng_ctrl_start == 1'b0 && eng_ctrl_ldm == 1'b0 &&
            eng_ctrl_inv == 1'b0 && eng_in_data == '0, "rst_async_eng", 64'(eng_in_data), 0);
        repeat (2) tick();
        reset = 1'b0;
        ok_stable = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (rsp_valid) ok_stable = 0;
        end
        chk(ok_stable == 1, "rst_no_rsp", 64'(ok_stable), 1);
        $display("txn reset mid-op abandoned");
        do_req(0, 1'b0, DIN, 32'h13579BDF, 1'b0, 1'b1, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
